instr_fetch: RTL

//  Instruction fetch unit: owns the program counter, issues reads to the synchronous instruction memory,
//  and buffers returned words in a small prefetch queue. Delivers instructions to the instruction

---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/instr_fetch_if.sv | 30 +++
 rtl/instr_fetch_ifq_fifo.sv | 50 +++++
 rtl/instr_fetch.sv | 76 +++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch slice: word/address types and the
// prefetch queue entry, which tags each fetched word with its own address.
package instr_fetch_pkg;

  localparam int IFQ_DEPTH = 4;

  typedef logic [15:0] iword_t;
  typedef logic [15:0] iaddr_t;

  typedef struct packed {
    iaddr_t pc;
    iword_t ins;
  } ifq_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: imem read port plus the il/ins load interface toward ir.
// The fetch unit is the master (producer) side.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int DATA_W = $bits(iword_t),
  parameter int ADDR_W = $bits(iaddr_t)
);

  logic              imem_req_out;
  logic [ADDR_W-1:0] imem_addr_out;
  logic [DATA_W-1:0] imem_data_in;
  logic              il_out;
  logic [DATA_W-1:0] ins_out;
  logic [ADDR_W-1:0] pc_out;
  logic              ir_ready_in;
  logic              jump_in;
  logic [ADDR_W-1:0] jump_addr_in;

  modport master (
    output imem_req_out, imem_addr_out, il_out, ins_out, pc_out,
    input  imem_data_in, ir_ready_in, jump_in, jump_addr_in
  );

  modport slave (
    input  imem_req_out, imem_addr_out, il_out, ins_out, pc_out,
    output imem_data_in, ir_ready_in, jump_in, jump_addr_in
  );

endinterface

// File: rtl/instr_fetch_ifq_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, ins} entries with flush and occupancy count.
// The head entry is read straight from storage, so it is valid whenever count != 0.
module ifq_fifo
  import instr_fetch_pkg::*;
#(
  parameter int W     = $bits(ifq_entry_t),
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          pop_ok, push_ok;

  // Guards keep the queue sane even if a caller misbehaves at the edges.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one-cycle-latency reads to imem,
// queues returned words and presents the queue head to ir over il/ins.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DATA_W = $bits(iword_t),
  parameter int ADDR_W = $bits(iaddr_t),
  parameter int DEPTH  = IFQ_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int KW = CW + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pc_p1;
  logic              vld_p1;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [EW-1:0]     hold;
  logic              show, pop, push, req;
  logic [KW-1:0]     credit;

  // A pop frees its slot in the same cycle, so it counts against occupancy immediately.
  always_comb begin
    show   = (count != '0) && !bus.jump_in;
    pop    = show && bus.ir_ready_in;
    push   = vld_p1 && !bus.jump_in;
    credit = KW'(count) + KW'(vld_p1) - KW'(pop);
    req    = !rst && !bus.jump_in && (credit < KW'(DEPTH));
  end

  // p0: fetch request
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0  <= '0;
      vld_p1 <= 1'b0;
      hold   <= '0;
    end else begin
      vld_p1 <= req;
      if (bus.jump_in)  pc_p0 <= bus.jump_addr_in;
      else if (req)     pc_p0 <= pc_p0 + ADDR_W'(1);
      if (show)         hold  <= head;
    end
  end

  // p1: return word arrives and is tagged with the address that fetched it
  always_ff @(posedge clk) begin
    if (req) pc_p1 <= pc_p0;
  end

  ifq_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_ifq (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({pc_p1, bus.imem_data_in}),
    .pop   (pop),
    .flush (bus.jump_in),
    .head  (head),
    .count (count)
  );

  assign bus.imem_req_out  = req;
  assign bus.imem_addr_out = pc_p0;
  assign bus.il_out        = show;
  // Outside a valid load the last presented pair is held, keeping pc/ins consistent.
  assign {bus.pc_out, bus.ins_out} = show ? head : hold;

endmodule
